// File: rtl/dot_int_acc_if.sv
// Beat and result handshake bundle for dot_int_acc.
// o_sat is present only when DOT_INT_ACC_SAT_EN is defined.
interface dot_int_acc_if #(
  parameter int bit_width = 8,
  parameter int k         = 4,
  parameter int n_beats   = 8,
  parameter int out_width = 2*bit_width + $clog2(k*n_beats) + 1
);

  logic [k-1:0][bit_width-1:0] i_vec_a;
  logic [k-1:0][bit_width-1:0] i_vec_b;
  logic                        i_signed;
  logic                        i_valid;
  logic                        o_ready;
  logic                        i_flush;
  logic [out_width-1:0]        o_acc;
  logic                        o_valid;
  logic                        i_ready;
  logic [$clog2(n_beats):0]    o_beat;
`ifdef DOT_INT_ACC_SAT_EN
  logic                        o_sat;

  modport master (
    output i_vec_a, i_vec_b, i_signed, i_valid, i_flush, i_ready,
    input  o_ready, o_acc, o_valid, o_beat, o_sat
  );

  modport slave (
    input  i_vec_a, i_vec_b, i_signed, i_valid, i_flush, i_ready,
    output o_ready, o_acc, o_valid, o_beat, o_sat
  );
`else
  modport master (
    output i_vec_a, i_vec_b, i_signed, i_valid, i_flush, i_ready,
    input  o_ready, o_acc, o_valid, o_beat
  );

  modport slave (
    input  i_vec_a, i_vec_b, i_signed, i_valid, i_flush, i_ready,
    output o_ready, o_acc, o_valid, o_beat
  );
`endif

endinterface

// File: rtl/dot_int_acc.sv
// Pipelined block dot-product accumulator: products, adder tree, then per-block accumulation.
// Define DOT_INT_ACC_SAT_EN to saturate o_acc to out_width and drive o_sat; otherwise o_acc wraps.
module dot_int_acc #(
  parameter int bit_width = 8,
  parameter int k         = 4,
  parameter int n_beats   = 8,
  parameter int acc_width = 2*bit_width + $clog2(k*n_beats) + 1,
  parameter int out_width = acc_width
) (
  input logic          i_clk,
  input logic          i_rst,
  dot_int_acc_if.slave bus
);

  localparam int ExtW   = bit_width + 1;
  localparam int ProdW  = 2*bit_width + 2;
  localparam int Levels = $clog2(k);
  localparam int SumW   = ProdW + Levels;
  localparam int BeatW  = $clog2(n_beats) + 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(n_beats - 1);

  logic adv;
  logic oReady;
  logic accept;
  logic flush;

  logic signed [ExtW-1:0]  extA [k];
  logic signed [ExtW-1:0]  extB [k];
  logic signed [ProdW-1:0] prodS1_q [k];
  logic signed [ProdW-1:0] prodS1_d [k];
  logic                    s1Valid_q, s1Valid_d;
  logic                    s1Last_q, s1Last_d;

  logic signed [SumW-1:0]  treeNode [k];
  logic signed [SumW-1:0]  sumS2_q, sumS2_d;
  logic                    s2Valid_q, s2Valid_d;
  logic                    s2Last_q, s2Last_d;

  logic signed [acc_width-1:0] acc_q, acc_d;
  logic signed [acc_width-1:0] accSum;
  logic                        load;
  logic [out_width-1:0]        narrowed;
  logic [out_width-1:0]        oAcc_q, oAcc_d;
  logic                        oValid_q, oValid_d;
  logic [BeatW-1:0]            beat_q, beat_d;

  // The whole pipeline moves only when the output slot is free or being drained.
  always_comb begin
    flush  = bus.i_flush;
    adv    = !oValid_q || bus.i_ready;
    oReady = adv && !i_rst && !flush;
    accept = bus.i_valid && oReady;
  end

  always_comb begin
    for (int j = 0; j < k; j++) begin
      extA[j] = $signed({bus.i_signed & bus.i_vec_a[j][bit_width-1], bus.i_vec_a[j]});
      extB[j] = $signed({bus.i_signed & bus.i_vec_b[j][bit_width-1], bus.i_vec_b[j]});
    end
  end

  always_comb begin
    s1Valid_d = s1Valid_q;
    s1Last_d  = s1Last_q;
    prodS1_d  = prodS1_q;
    if (flush) begin
      s1Valid_d = 1'b0;
    end else if (adv) begin
      s1Valid_d = accept;
      if (accept) begin
        s1Last_d = (beat_q == LastBeat);
        for (int j = 0; j < k; j++) begin
          prodS1_d[j] = ProdW'(extA[j]) * ProdW'(extB[j]);
        end
      end
    end
  end

  // Pairwise tree reduced in place; nodes carry the final width so each level's growth fits.
  always_comb begin
    for (int j = 0; j < k; j++) begin
      treeNode[j] = SumW'(prodS1_q[j]);
    end
    for (int l = 0; l < Levels; l++) begin
      for (int j = 0; j < k/2; j++) begin
        if (j < (k >> (l + 1))) begin
          treeNode[j] = treeNode[2*j] + treeNode[2*j+1];
        end
      end
    end
  end

  always_comb begin
    s2Valid_d = s2Valid_q;
    s2Last_d  = s2Last_q;
    sumS2_d   = sumS2_q;
    if (flush) begin
      s2Valid_d = 1'b0;
    end else if (adv) begin
      s2Valid_d = s1Valid_q;
      if (s1Valid_q) begin
        sumS2_d  = treeNode[0];
        s2Last_d = s1Last_q;
      end
    end
  end

  assign accSum = acc_q + acc_width'(sumS2_q);
  assign load   = adv && !flush && s2Valid_q && s2Last_q;

  always_comb begin
    acc_d    = acc_q;
    oAcc_d   = oAcc_q;
    oValid_d = oValid_q;
    if (flush) begin
      acc_d = '0;
    end else if (adv && s2Valid_q) begin
      acc_d = s2Last_q ? '0 : accSum;
    end
    if (adv) begin
      oValid_d = load;
    end
    if (load) begin
      oAcc_d = narrowed;
    end
  end

  always_comb begin
    beat_d = beat_q;
    if (flush) begin
      beat_d = '0;
    end else if (accept) begin
      beat_d = (beat_q == LastBeat) ? '0 : beat_q + BeatW'(1);
    end
  end

`ifdef DOT_INT_ACC_SAT_EN
  localparam logic signed [acc_width-1:0] SatMax =
    {{(acc_width-out_width+1){1'b0}}, {(out_width-1){1'b1}}};
  localparam logic signed [acc_width-1:0] SatMin =
    {{(acc_width-out_width+1){1'b1}}, {(out_width-1){1'b0}}};

  logic clip;
  logic sat_q, sat_d;

  always_comb begin
    clip     = 1'b0;
    narrowed = accSum[out_width-1:0];
    if (accSum > SatMax) begin
      clip     = 1'b1;
      narrowed = SatMax[out_width-1:0];
    end else if (accSum < SatMin) begin
      clip     = 1'b1;
      narrowed = SatMin[out_width-1:0];
    end
  end

  always_comb begin
    sat_d = sat_q;
    if (adv) begin
      sat_d = load && clip;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign bus.o_sat = sat_q;
`else
  assign narrowed = accSum[out_width-1:0];
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      prodS1_q  <= '{default: '0};
      s1Valid_q <= 1'b0;
      s1Last_q  <= 1'b0;
      sumS2_q   <= '0;
      s2Valid_q <= 1'b0;
      s2Last_q  <= 1'b0;
      acc_q     <= '0;
      oAcc_q    <= '0;
      oValid_q  <= 1'b0;
      beat_q    <= '0;
    end else begin
      prodS1_q  <= prodS1_d;
      s1Valid_q <= s1Valid_d;
      s1Last_q  <= s1Last_d;
      sumS2_q   <= sumS2_d;
      s2Valid_q <= s2Valid_d;
      s2Last_q  <= s2Last_d;
      acc_q     <= acc_d;
      oAcc_q    <= oAcc_d;
      oValid_q  <= oValid_d;
      beat_q    <= beat_d;
    end
  end

  assign bus.o_ready = oReady;
  assign bus.o_acc   = oAcc_q;
  assign bus.o_valid = oValid_q;
  assign bus.o_beat  = beat_q;

endmodule

// File: tb/tb_dot_int_acc.sv
// Randomized and directed bench for dot_int_acc against a block-level dot-product model.
// A second instance with out_width=16 exercises narrowing (saturating when DOT_INT_ACC_SAT_EN is defined).
module tb_dot_int_acc;

  localparam int BW      = 8;
  localparam int K       = 4;
  localparam int NB      = 8;
  localparam int AccW    = 2*BW + $clog2(K*NB) + 1;
  localparam int NarrowW = 16;

  typedef logic [K-1:0][BW-1:0] vec_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dot_int_acc_if #(.bit_width(BW), .k(K), .n_beats(NB), .out_width(AccW))    bus ();
  dot_int_acc_if #(.bit_width(BW), .k(K), .n_beats(NB), .out_width(NarrowW)) nbus ();

  dot_int_acc #(.bit_width(BW), .k(K), .n_beats(NB)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  dot_int_acc #(.bit_width(BW), .k(K), .n_beats(NB), .out_width(NarrowW)) ndut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (nbus)
  );

  assign nbus.i_vec_a  = bus.i_vec_a;
  assign nbus.i_vec_b  = bus.i_vec_b;
  assign nbus.i_signed = bus.i_signed;
  assign nbus.i_valid  = bus.i_valid;
  assign nbus.i_flush  = bus.i_flush;
  assign nbus.i_ready  = bus.i_ready;

  int     vectors     = 0;
  int     miscompares = 0;
  int     cycle       = 0;
  longint expQ[$];
  longint partial     = 0;
  int     beatCnt     = 0;
  bit     lastAccepted;
  bit     armLatency  = 1'b0;
  bit     latArmed    = 1'b0;
  int     latStamp    = 0;

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0d, required %0d", tag, actual, expected);
    end
  endtask

  // Dot product straight from the operand-interpretation rules.
  function automatic longint dotModel(input vec_t a, input vec_t b, input bit sgn);
    longint s = 0;
    longint x;
    longint y;
    for (int j = 0; j < K; j++) begin
      x = sgn ? longint'($signed(a[j])) : longint'(a[j]);
      y = sgn ? longint'($signed(b[j])) : longint'(b[j]);
      s += x * y;
    end
    return s;
  endfunction

  function automatic longint narrowExp(input longint x);
    logic [NarrowW-1:0] lo;
    longint lim = longint'(1) <<< (NarrowW - 1);
`ifdef DOT_INT_ACC_SAT_EN
    if (x > lim - 1) return lim - 1;
    if (x < -lim) return -lim;
    return x;
`else
    lo = x[NarrowW-1:0];
    if (lim == 0) return 0;
    return longint'($signed(lo));
`endif
  endfunction

`ifdef DOT_INT_ACC_SAT_EN
  function automatic longint satExp(input longint x);
    longint lim = longint'(1) <<< (NarrowW - 1);
    return (x > lim - 1 || x < -lim) ? 1 : 0;
  endfunction
`endif

  function automatic vec_t randVec();
    vec_t v;
    for (int j = 0; j < K; j++) v[j] = BW'($urandom());
    return v;
  endfunction

  // Called just after a falling edge: drive, check settled outputs, update the model, advance one cycle.
  task automatic applyStimulus(input bit v, input vec_t a, input vec_t b, input bit sgn,
                               input bit fl, input bit rdy);
    bit expReady;
    bus.i_valid  = v;
    bus.i_vec_a  = a;
    bus.i_vec_b  = b;
    bus.i_signed = sgn;
    bus.i_flush  = fl;
    bus.i_ready  = rdy;
    #1;
    expReady = (!bus.o_valid || rdy) && !fl;
    checkOutput("o_ready", longint'(bus.o_ready), longint'(expReady));
    checkOutput("o_beat", longint'(bus.o_beat), longint'(beatCnt));
    if (bus.o_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("o_valid_spurious", longint'(bus.o_valid), 0);
      end else begin
        checkOutput("o_acc", longint'($signed(bus.o_acc)), expQ[0]);
        checkOutput("narrow_acc", longint'($signed(nbus.o_acc)), narrowExp(expQ[0]));
`ifdef DOT_INT_ACC_SAT_EN
        checkOutput("o_sat", longint'(bus.o_sat), 0);
        checkOutput("narrow_sat", longint'(nbus.o_sat), satExp(expQ[0]));
`endif
        if (latArmed) begin
          checkOutput("latency", longint'(cycle - latStamp), 3);
          latArmed = 1'b0;
        end
        if (rdy) void'(expQ.pop_front());
      end
    end
    lastAccepted = v && expReady;
    if (fl) begin
      partial = 0;
      beatCnt = 0;
    end else if (lastAccepted) begin
      partial += dotModel(a, b, sgn);
      beatCnt++;
      if (beatCnt == NB) begin
        expQ.push_back(partial);
        partial = 0;
        beatCnt = 0;
        if (armLatency) begin
          latArmed   = 1'b1;
          latStamp   = cycle;
          armLatency = 1'b0;
        end
      end
    end
    @(posedge clk);
    cycle++;
    @(negedge clk);
  endtask

  task automatic sendBeats(input int n, input vec_t a, input vec_t b, input bit sgn);
    int got = 0;
    int guard = 0;
    while (got < n) begin
      if (guard >= 200) begin
        checkOutput("send_timeout", longint'(got), longint'(n));
        break;
      end
      applyStimulus(1'b1, a, b, sgn, 1'b0, 1'b1);
      if (lastAccepted) got++;
      guard++;
    end
  endtask

  task automatic drain();
    int g = 0;
    while (expQ.size() != 0 && g < 60) begin
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      g++;
    end
    checkOutput("drained", longint'(expQ.size()), 0);
    repeat (3) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int sent;
    int hold;
    bit started;
    int guard;
    vec_t ones;
    ones = {K{BW'(1)}};

    rst          = 1'b1;
    bus.i_valid  = 1'b1;
    bus.i_vec_a  = '0;
    bus.i_vec_b  = '0;
    bus.i_signed = 1'b0;
    bus.i_flush  = 1'b0;
    bus.i_ready  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_o_ready", longint'(bus.o_ready), 0);
    checkOutput("rst_o_valid", longint'(bus.o_valid), 0);
    checkOutput("rst_o_acc", longint'(bus.o_acc), 0);
    checkOutput("rst_o_beat", longint'(bus.o_beat), 0);
    rst         = 1'b0;
    bus.i_valid = 1'b0;

    armLatency = 1'b1;
    sendBeats(NB, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 1'b1);
    drain();

    sendBeats(NB, {K{8'h80}}, {K{8'h80}}, 1'b1);
    sendBeats(NB, {K{8'h80}}, {K{8'h7f}}, 1'b1);
    drain();

    sendBeats(NB, {K{8'hff}}, {K{8'hff}}, 1'b0);
    sendBeats(NB, {K{8'hff}}, {K{8'hff}}, 1'b1);
    sendBeats(NB, {K{8'h7f}}, {K{8'h7f}}, 1'b1);
    drain();

    sendBeats(3, ones, ones, 1'b1);
    applyStimulus(1'b1, ones, ones, 1'b1, 1'b1, 1'b1);
    sendBeats(NB, ones, ones, 1'b1);
    drain();

    sent    = 0;
    hold    = 0;
    started = 1'b0;
    guard   = 0;
    while ((sent < 2*NB || expQ.size() != 0) && guard < 300) begin
      if (bus.o_valid && !started) begin
        started = 1'b1;
        hold    = 5;
      end
      applyStimulus(sent < 2*NB, randVec(), randVec(), 1'b1, 1'b0, hold == 0);
      if (hold > 0) hold--;
      if (lastAccepted) sent++;
      guard++;
    end
    checkOutput("bp_beats", longint'(sent), 2*NB);
    drain();

    for (int i = 0; i < 2500; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, randVec(), randVec(), 1'($urandom_range(0, 1)),
                    (beatCnt >= 2) && ($urandom_range(0, 49) == 0),
                    $urandom_range(0, 9) < 7);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
